// File: rtl/vend_pkg.sv
// Shared state encoding and default datapath/price constants for the vending
// machine credit controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD    = 2'd1,
    DISP   = 2'd2,
    REFUND = 2'd3
  } vend_state_e;

  localparam int W_DEF       = 8;
  localparam int PRICE0_DEF  = 50;
  localparam int PRICE1_DEF  = 75;
  localparam int PRICE2_DEF  = 100;
  localparam int PRICE3_DEF  = 150;
  localparam int TIMEOUT_DEF = 200;

endpackage

// File: rtl/vend_price_lut.sv
// Combinational product-select to price lookup.
module vend_price_lut
  import vend_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int PRICE0 = PRICE0_DEF,
  parameter int PRICE1 = PRICE1_DEF,
  parameter int PRICE2 = PRICE2_DEF,
  parameter int PRICE3 = PRICE3_DEF
) (
  input  logic [1:0]   sel_i,
  output logic [W-1:0] price_o
);

  always_comb begin
    price_o = W'(PRICE0);
    case (sel_i)
      2'd0:    price_o = W'(PRICE0);
      2'd1:    price_o = W'(PRICE1);
      2'd2:    price_o = W'(PRICE2);
      default: price_o = W'(PRICE3);
    endcase
  end

endmodule

// File: rtl/vend_controller.sv
// Coin-credit sequencing controller: coin edge capture, saturating credit add,
// buy/cancel resolution against the price table and inactivity refund.
module vend_controller
  import vend_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int PRICE0  = PRICE0_DEF,
  parameter int PRICE1  = PRICE1_DEF,
  parameter int PRICE2  = PRICE2_DEF,
  parameter int PRICE3  = PRICE3_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         coin_n,
  input  logic [W-1:0] coin_val,
  input  logic [1:0]   sel,
  input  logic         buy,
  input  logic         cancel,
  output logic [W-1:0] credit,
  output logic         dispense,
  output logic [1:0]   prod_out,
  output logic [W-1:0] change,
  output logic         change_valid,
  output logic         coin_reject,
  output logic         no_credit,
  output logic         busy
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

  vend_state_e      state_q, state_d;
  logic [W-1:0]     credit_q, credit_d;
  logic             coin_prev_q, coin_prev_d;
  logic             coin_pend_q, coin_pend_d;
  logic [W-1:0]     coin_reg_q, coin_reg_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dispense_q, dispense_d;
  logic [1:0]       prod_q, prod_d;
  logic [W-1:0]     change_q, change_d;
  logic             change_valid_q, change_valid_d;
  logic             coin_reject_q, coin_reject_d;
  logic             no_credit_q, no_credit_d;

  logic [1:0]       lut_sel;
  logic [W-1:0]     price;
  logic [W:0]       sum;
  logic             coin_edge;

  // In DISP the latched selection prices the change; in IDLE the live select does.
  assign lut_sel = (state_q == DISP) ? sel_q : sel;

  vend_price_lut #(
    .W      (W),
    .PRICE0 (PRICE0),
    .PRICE1 (PRICE1),
    .PRICE2 (PRICE2),
    .PRICE3 (PRICE3)
  ) u_price_lut (
    .sel_i   (lut_sel),
    .price_o (price)
  );

  assign coin_edge = coin_prev_q & ~coin_n;
  assign sum       = {1'b0, credit_q} + {1'b0, coin_reg_q};

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    coin_prev_d    = coin_n;
    coin_pend_d    = coin_pend_q;
    coin_reg_d     = coin_reg_q;
    sel_d          = sel_q;
    cnt_d          = '0;
    dispense_d     = 1'b0;
    prod_d         = prod_q;
    change_d       = change_q;
    change_valid_d = 1'b0;
    coin_reject_d  = 1'b0;
    no_credit_d    = 1'b0;

    // A pending coin blocks further captures until ADD consumes it.
    if (coin_pend_q) begin
      if (state_q == ADD) begin
        coin_pend_d = 1'b0;
      end
    end else if (coin_edge) begin
      coin_pend_d = 1'b1;
      coin_reg_d  = coin_val;
    end

    case (state_q)
      IDLE: begin
        if (cancel && (credit_q != '0)) begin
          state_d = REFUND;
        end else if (buy) begin
          if (credit_q >= price) begin
            state_d = DISP;
            sel_d   = sel;
          end else begin
            no_credit_d = 1'b1;
          end
        end else if (coin_pend_q) begin
          state_d = ADD;
        end else if (credit_q != '0) begin
          if (cnt_q == CNT_LAST) begin
            state_d = REFUND;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ADD: begin
        if (sum[W]) begin
          coin_reject_d = 1'b1;
        end else begin
          credit_d = sum[W-1:0];
        end
        state_d = IDLE;
      end
      DISP: begin
        dispense_d     = 1'b1;
        prod_d         = sel_q;
        change_d       = credit_q - price;
        change_valid_d = 1'b1;
        credit_d       = '0;
        state_d        = IDLE;
      end
      default: begin
        change_d       = credit_q;
        change_valid_d = 1'b1;
        credit_d       = '0;
        state_d        = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      coin_prev_q    <= 1'b1;
      coin_pend_q    <= 1'b0;
      coin_reg_q     <= '0;
      sel_q          <= '0;
      cnt_q          <= '0;
      dispense_q     <= 1'b0;
      prod_q         <= '0;
      change_q       <= '0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      no_credit_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      coin_prev_q    <= coin_prev_d;
      coin_pend_q    <= coin_pend_d;
      coin_reg_q     <= coin_reg_d;
      sel_q          <= sel_d;
      cnt_q          <= cnt_d;
      dispense_q     <= dispense_d;
      prod_q         <= prod_d;
      change_q       <= change_d;
      change_valid_q <= change_valid_d;
      coin_reject_q  <= coin_reject_d;
      no_credit_q    <= no_credit_d;
    end
  end

  assign credit       = credit_q;
  assign dispense     = dispense_q;
  assign prod_out     = prod_q;
  assign change       = change_q;
  assign change_valid = change_valid_q;
  assign coin_reject  = coin_reject_q;
  assign no_credit    = no_credit_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios plus random
// traffic, compared every cycle against a transaction-level vending model.
module tb_vend_controller;

  localparam int W          = 8;
  localparam int TB_TIMEOUT = 16;
  localparam int MAXC       = 255;
  localparam int A_NONE = 0, A_ADD = 1, A_DISP = 2, A_REF = 3;

  int prices [4] = '{50, 75, 100, 150};
  int coinSet[6] = '{5, 10, 25, 50, 100, 200};

  logic         clk = 1'b0;
  logic         rst;
  logic         coin_n;
  logic [W-1:0] coin_val;
  logic [1:0]   sel;
  logic         buy;
  logic         cancel;
  logic [W-1:0] credit;
  logic         dispense;
  logic [1:0]   prod_out;
  logic [W-1:0] change;
  logic         change_valid;
  logic         coin_reject;
  logic         no_credit;
  logic         busy;

  int vecCount  = 0;
  int missCount = 0;

  // Reference model: credit balance, one-deep coin slot, the action the
  // machine is carrying out next cycle, and a count of quiet idle cycles.
  int mCredit, mCoin, mSel, mQuiet, mAct;
  bit mPend, mPrev;
  int eProd, eChange;
  bit eDisp, eCv, eRej, eNoc;

  always #5 clk = ~clk;

  vend_controller #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .coin_n       (coin_n),
    .coin_val     (coin_val),
    .sel          (sel),
    .buy          (buy),
    .cancel       (cancel),
    .credit       (credit),
    .dispense     (dispense),
    .prod_out     (prod_out),
    .change       (change),
    .change_valid (change_valid),
    .coin_reject  (coin_reject),
    .no_credit    (no_credit),
    .busy         (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mCredit = 0; mCoin = 0; mSel = 0; mQuiet = 0; mAct = A_NONE;
    mPend = 0; mPrev = 1;
    eProd = 0; eChange = 0; eDisp = 0; eCv = 0; eRej = 0; eNoc = 0;
  endtask

  // Advances the model by one clock using the inputs currently driven.
  task automatic modelStep();
    int  nextAct;
    bit  edgeSeen, pendOld, refundReq;
    nextAct  = A_NONE;
    eDisp = 0; eCv = 0; eRej = 0; eNoc = 0;
    edgeSeen = mPrev && !coin_n;
    mPrev    = coin_n;
    pendOld  = mPend;
    if (mAct == A_ADD) begin
      if (mCredit + mCoin > MAXC) eRej = 1;
      else mCredit = mCredit + mCoin;
      mPend  = 0;
      mQuiet = 0;
    end else if (mAct == A_DISP) begin
      eDisp = 1; eProd = mSel; eCv = 1;
      eChange = mCredit - prices[mSel];
      mCredit = 0; mQuiet = 0;
    end else if (mAct == A_REF) begin
      eCv = 1; eChange = mCredit;
      mCredit = 0; mQuiet = 0;
    end else begin
      refundReq = cancel && (mCredit > 0);
      if (refundReq) nextAct = A_REF;
      else if (buy) begin
        if (mCredit >= prices[sel]) begin
          nextAct = A_DISP;
          mSel = int'(sel);
        end else eNoc = 1;
      end else if (pendOld) nextAct = A_ADD;
      if (mCredit > 0 && !buy && !cancel && !pendOld) begin
        mQuiet++;
        if (mQuiet == TB_TIMEOUT - 1) begin
          nextAct = A_REF;
          mQuiet  = 0;
        end
      end else mQuiet = 0;
    end
    if (!pendOld && edgeSeen) begin
      mPend = 1;
      mCoin = int'(coin_val);
    end
    mAct = nextAct;
  endtask

  task automatic compareAll();
    checkOutput("credit", credit, mCredit);
    checkOutput("dispense", dispense, eDisp);
    checkOutput("prod_out", prod_out, eProd);
    checkOutput("change", change, eChange);
    checkOutput("change_valid", change_valid, eCv);
    checkOutput("coin_reject", coin_reject, eRej);
    checkOutput("no_credit", no_credit, eNoc);
    checkOutput("busy", busy, mAct != A_NONE);
  endtask

  task automatic applyStimulus(input logic cn, input logic [W-1:0] cv, input logic [1:0] s,
                               input logic b, input logic c);
    coin_n = cn; coin_val = cv; sel = s; buy = b; cancel = c;
    modelStep();
    @(posedge clk);
    #1;
    compareAll();
  endtask

  task automatic idleCycle();
    applyStimulus(1'b1, '0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic insertCoin(input int v);
    applyStimulus(1'b0, W'(v), 2'd0, 1'b0, 1'b0);
    idleCycle();
    idleCycle();
  endtask

  initial begin
    modelReset();
    rst = 1'b0; coin_n = 1'b1; coin_val = '0; sel = '0; buy = 1'b0; cancel = 1'b0;
    #12;
    compareAll();
    @(negedge clk);
    rst = 1'b1;

    // Two coins then an exact-price purchase of product 1.
    insertCoin(50);
    checkOutput("coin50_credit", credit, 50);
    insertCoin(25);
    checkOutput("coin25_credit", credit, 75);
    applyStimulus(1'b1, '0, 2'd1, 1'b1, 1'b0);
    idleCycle();
    checkOutput("buy1_dispense", dispense, 1);
    checkOutput("buy1_prod", prod_out, 1);
    checkOutput("buy1_change", change, 0);
    checkOutput("buy1_cv", change_valid, 1);
    checkOutput("buy1_credit", credit, 0);

    // Underfunded buy, then funded buy with change.
    insertCoin(100);
    applyStimulus(1'b1, '0, 2'd3, 1'b1, 1'b0);
    checkOutput("short_nocredit", no_credit, 1);
    checkOutput("short_credit", credit, 100);
    insertCoin(100);
    applyStimulus(1'b1, '0, 2'd3, 1'b1, 1'b0);
    idleCycle();
    checkOutput("buy3_prod", prod_out, 3);
    checkOutput("buy3_change", change, 50);

    // Overflowing coin is rejected, then cancel refunds the full credit.
    insertCoin(200);
    insertCoin(100);
    checkOutput("ovf_reject", coin_reject, 1);
    checkOutput("ovf_credit", credit, 200);
    applyStimulus(1'b1, '0, 2'd0, 1'b0, 1'b1);
    idleCycle();
    checkOutput("cancel_change", change, 200);
    checkOutput("cancel_credit", credit, 0);

    // Cancel beats buy in the same cycle.
    insertCoin(80);
    applyStimulus(1'b1, '0, 2'd0, 1'b1, 1'b1);
    idleCycle();
    checkOutput("race_change", change, 80);
    checkOutput("race_dispense", dispense, 0);
    checkOutput("race_cv", change_valid, 1);

    // Inactivity refund lands exactly TIMEOUT cycles after the credit update.
    insertCoin(10);
    repeat (TB_TIMEOUT - 1) idleCycle();
    checkOutput("timeout_early_cv", change_valid, 0);
    idleCycle();
    checkOutput("timeout_cv", change_valid, 1);
    checkOutput("timeout_change", change, 10);
    applyStimulus(1'b1, '0, 2'd0, 1'b0, 1'b1);
    idleCycle();
    checkOutput("zero_cancel_cv", change_valid, 0);

    // Asynchronous reset while ADD is in progress.
    insertCoin(40);
    applyStimulus(1'b0, 8'd30, 2'd0, 1'b0, 1'b0);
    idleCycle();
    checkOutput("midadd_busy", busy, 1);
    #2;
    rst = 1'b0;
    modelReset();
    #1;
    compareAll();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) idleCycle();
    checkOutput("post_reset_credit", credit, 0);

    // Random traffic with periodic quiet windows long enough to time out.
    for (int i = 0; i < 3000; i++) begin
      bit quietPhase;
      quietPhase = (((i / 40) % 4) == 3);
      applyStimulus(quietPhase ? 1'b1 : ($urandom_range(0, 2) != 0),
                    W'(coinSet[$urandom_range(0, 5)]),
                    2'($urandom_range(0, 3)),
                    !quietPhase && ($urandom_range(0, 7) == 0),
                    !quietPhase && ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
